// File: rtl/counter_pkg.sv
// Shared mode encodings and button indices for the
// multi-mode counter.
package counter_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_UP   = 2'd1,
    AUTO_DOWN = 2'd2
  } mode_e;

  localparam int BTN_INC  = 0;
  localparam int BTN_DEC  = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_CLR  = 3;

  function automatic mode_e next_mode(mode_e m);
    unique case (m)
      MANUAL:  return AUTO_UP;
      AUTO_UP: return AUTO_DOWN;
      default: return MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider that flags the last cycle of
// each auto-step interval while enabled.
module tick_divider #(
  parameter int CYCLES_PER_TICK = 125_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CYCLES_PER_TICK);
  localparam logic [W-1:0] LAST = W'(CYCLES_PER_TICK - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || !enable || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_mode_counter.sv
// Up/down counter with manual button stepping and
// timed auto-up / auto-down modes.
module multi_mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int CYCLES_PER_TICK = 125_000_000,
  parameter int SATURATE        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       buttons,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       mode,
  output logic             tick,
  output logic             bound
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  mode_e            mode_q;
  mode_e            mode_d;
  logic             tick_q;
  logic             tick_d;
  logic             bound_q;
  logic             bound_d;
  logic             auto_en;
  logic             div_clr;
  logic             div_tick;
  logic             step_up;
  logic             step_dn;

  assign auto_en = (mode_q == AUTO_UP) || (mode_q == AUTO_DOWN);
  assign div_clr = buttons[BTN_MODE] | buttons[BTN_CLR];

  tick_divider #(
    .CYCLES_PER_TICK(CYCLES_PER_TICK)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(auto_en),
    .clear (div_clr),
    .tick  (div_tick)
  );

  always_comb begin
    count_d = count_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    bound_d = 1'b0;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (buttons[BTN_MODE]) begin
      mode_d = next_mode(mode_q);
    end
    if (!auto_en) begin
      if (buttons[BTN_INC]) begin
        step_up = 1'b1;
      end else if (buttons[BTN_DEC]) begin
        step_dn = 1'b1;
      end else if (buttons[BTN_CLR]) begin
        count_d = '0;
      end
    end else if (buttons[BTN_CLR]) begin
      count_d = '0;
    end else if (div_tick && !buttons[BTN_MODE]) begin
      tick_d  = 1'b1;
      step_up = (mode_q == AUTO_UP);
      step_dn = (mode_q == AUTO_DOWN);
    end
    // Bound steps either wrap or clamp, and always flag.
    if (step_up) begin
      if (count_q == MAX) begin
        bound_d = 1'b1;
        count_d = (SATURATE != 0) ? MAX : '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
    if (step_dn) begin
      if (count_q == '0) begin
        bound_d = 1'b1;
        count_d = (SATURATE != 0) ? '0 : MAX;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      mode_q  <= MANUAL;
      tick_q  <= 1'b0;
      bound_q <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      bound_q <= bound_d;
    end
  end

  assign count = count_q;
  assign mode  = mode_q;
  assign tick  = tick_q;
  assign bound = bound_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Bench for multi_mode_counter: wrap and saturate
// instances driven in parallel against a reference model.
module tb_multi_mode_counter;

  localparam int W   = 4;
  localparam int CPT = 4;
  localparam int TOP = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   buttons = 4'b0;
  logic [W-1:0] count0;
  logic [W-1:0] count1;
  logic [1:0]   mode0;
  logic [1:0]   mode1;
  logic         tick0;
  logic         tick1;
  logic         bound0;
  logic         bound1;

  always #5 clk = ~clk;

  multi_mode_counter #(
    .WIDTH(W), .CYCLES_PER_TICK(CPT), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .buttons(buttons),
    .count(count0), .mode(mode0),
    .tick(tick0), .bound(bound0)
  );

  multi_mode_counter #(
    .WIDTH(W), .CYCLES_PER_TICK(CPT), .SATURATE(1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .buttons(buttons),
    .count(count1), .mode(mode1),
    .tick(tick1), .bound(bound1)
  );

  int total = 0;
  int passed = 0;

  int m_cnt[2];
  int m_bnd[2];
  int m_mode;
  int m_phase;
  int m_tick;

  typedef struct {
    logic [3:0] btn;
    int         cnt;
    int         bnd;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic model_reset();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_bnd[0] = 0;
    m_bnd[1] = 0;
    m_mode   = 0;
    m_phase  = 0;
    m_tick   = 0;
  endtask

  // Phase = cycles elapsed since the interval started.
  task automatic model_step(input logic [3:0] b);
    int  delta;
    int  raw;
    bit  clr;
    bit  auto_m;
    auto_m = (m_mode != 0);
    m_tick = 0;
    delta  = 0;
    if (!auto_m) begin
      clr   = !b[0] && !b[1] && b[3];
      delta = b[0] ? 1 : (b[1] ? -1 : 0);
    end else begin
      clr = b[3];
      if (!b[2] && !b[3] && m_phase == CPT - 1) begin
        m_tick = 1;
        delta  = (m_mode == 1) ? 1 : -1;
      end
    end
    for (int s = 0; s < 2; s++) begin
      m_bnd[s] = 0;
      if (clr) begin
        m_cnt[s] = 0;
      end else if (delta != 0) begin
        raw = m_cnt[s] + delta;
        if (raw < 0 || raw > TOP) begin
          m_bnd[s] = 1;
          if (s == 1) raw = (raw < 0) ? 0 : TOP;
          else raw = (raw + TOP + 1) % (TOP + 1);
        end
        m_cnt[s] = raw;
      end
    end
    if (b[2] || b[3] || !auto_m || m_phase == CPT - 1)
      m_phase = 0;
    else
      m_phase = m_phase + 1;
    if (b[2]) m_mode = (m_mode + 1) % 3;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cnt0"}, int'(count0), m_cnt[0]);
    chk({tag, "_cnt1"}, int'(count1), m_cnt[1]);
    chk({tag, "_mode"}, int'(mode0), m_mode);
    chk({tag, "_mode1"}, int'(mode1), m_mode);
    chk({tag, "_tick"}, int'(tick0), m_tick);
    chk({tag, "_tick1"}, int'(tick1), m_tick);
    chk({tag, "_bnd0"}, int'(bound0), m_bnd[0]);
    chk({tag, "_bnd1"}, int'(bound1), m_bnd[1]);
  endtask

  task automatic cyc(input logic [3:0] b);
    buttons = b;
    @(posedge clk);
    #1;
    model_step(b);
    buttons = 4'b0;
    check_model("model");
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    buttons = 4'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rb;

    tbl[0] = '{4'b0010, 15, 1};
    tbl[1] = '{4'b0000, 15, 0};
    tbl[2] = '{4'b0001, 0, 1};
    tbl[3] = '{4'b0001, 1, 0};
    tbl[4] = '{4'b0001, 2, 0};
    tbl[5] = '{4'b0001, 3, 0};
    tbl[6] = '{4'b1011, 4, 0};
    tbl[7] = '{4'b1010, 3, 0};
    tbl[8] = '{4'b1000, 0, 0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].btn);
      chk("tbl_cnt", int'(count0), tbl[i].cnt);
      chk("tbl_bnd", int'(bound0), tbl[i].bnd);
      chk("tbl_mode", int'(mode0), 0);
    end

    // Auto-up with ignored inc/dec noise.
    do_reset();
    cyc(4'b0100);
    chk("au_mode", int'(mode0), 1);
    for (int k = 1; k <= 12; k++) begin
      cyc(4'($urandom_range(0, 3)));
      chk("au_tick", int'(tick0), (k % 4 == 0) ? 1 : 0);
    end
    chk("au_cnt", int'(count0), 3);

    // Saturation in auto-down.
    do_reset();
    cyc(4'b0001);
    cyc(4'b0100);
    cyc(4'b0100);
    chk("sat_mode", int'(mode1), 2);
    for (int k = 1; k <= 8; k++) begin
      cyc(4'b0000);
      if (k == 4) begin
        chk("sat_first_cnt", int'(count1), 0);
        chk("sat_first_tick", int'(tick1), 1);
      end
      if (k == 8) begin
        chk("sat_hold_cnt", int'(count1), 0);
        chk("sat_hold_bnd", int'(bound1), 1);
        chk("wrap_cnt", int'(count0), 15);
      end
    end

    // Clear colliding with a due tick.
    do_reset();
    cyc(4'b0100);
    repeat (4) cyc(4'b0000);
    chk("col_pre", int'(count0), 1);
    repeat (3) cyc(4'b0000);
    cyc(4'b1000);
    chk("col_cnt", int'(count0), 0);
    chk("col_tick", int'(tick0), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(4'b0000);
      chk("col_next_tick", int'(tick0), (k == 4) ? 1 : 0);
    end
    chk("col_next_cnt", int'(count0), 1);

    // Asynchronous reset mid-interval.
    do_reset();
    cyc(4'b0100);
    repeat (20) cyc(4'b0000);
    chk("mr_pre", int'(count0), 5);
    repeat (2) cyc(4'b0000);
    rst_n = 1'b0;
    #1;
    chk("mr_cnt", int'(count0), 0);
    chk("mr_mode", int'(mode0), 0);
    chk("mr_cnt1", int'(count1), 0);
    chk("mr_tick", int'(tick0), 0);
    chk("mr_bnd", int'(bound0), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) cyc(4'b0000);
    chk("mr_idle_cnt", int'(count0), 0);
    chk("mr_idle_mode", int'(mode0), 0);

    // Random sparse button pulses.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < 4; j++)
        rb[j] = ($urandom_range(0, 7) == 0);
      cyc(rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
